// File: rtl/branch_control.sv
// Control-flow stage ahead of the PC: resolves branch/jump/call/return,
// keeps a return-address stack and squashes wrong-path instructions.
// Ports:
//   Clock, Reset (sync, active-high)
//   InstrValid, Instr, InstrPC, RegValue, FlagZ/N/C : instruction in
//   LoadEnable, LoadValue, OffsetEnable, Offset     : PC controls
//   Squash, StackCount, StackError                  : status
module branch_control #(
  parameter int STACK_DEPTH   = 8,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         InstrValid,
  input  logic [15:0]                  Instr,
  input  logic [15:0]                  InstrPC,
  input  logic [15:0]                  RegValue,
  input  logic                         FlagZ,
  input  logic                         FlagN,
  input  logic                         FlagC,
  output logic                         LoadEnable,
  output logic [15:0]                  LoadValue,
  output logic                         OffsetEnable,
  output logic [8:0]                   Offset,
  output logic                         Squash,
  output logic [$clog2(STACK_DEPTH):0] StackCount,
  output logic                         StackError
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SQUASH_CYCLES + 1);

  logic          le_q, le_d;
  logic          oe_q, oe_d;
  logic [15:0]   lv_q, lv_d;
  logic [8:0]    off_q, off_d;
  logic [SW-1:0] sq_q, sq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [15:0]   stack_q [STACK_DEPTH];
  logic [15:0]   stack_d [STACK_DEPTH];

  logic          accept;
  logic          br_taken;
  logic [PW-1:0] top_idx;

  assign accept  = InstrValid && (sq_q == '0);
  assign top_idx = PW'(cnt_q - 1'b1);

  always_comb begin
    br_taken = 1'b0;
    case (Instr[11:9])
      3'b000: br_taken = 1'b1;
      3'b001: br_taken = FlagZ;
      3'b010: br_taken = !FlagZ;
      3'b011: br_taken = FlagN;
      3'b100: br_taken = !FlagN;
      3'b101: br_taken = FlagC;
      3'b110: br_taken = !FlagC;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    le_d    = 1'b0;
    oe_d    = 1'b0;
    lv_d    = lv_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stack_d = stack_q;
    sq_d    = (sq_q != '0) ? sq_q - 1'b1 : sq_q;
    if (accept) begin
      case (Instr[15:12])
        4'hC: begin
          if (br_taken) begin
            oe_d  = 1'b1;
            off_d = Instr[8:0];
            sq_d  = SW'(SQUASH_CYCLES);
          end
        end
        4'hD: begin
          le_d = 1'b1;
          lv_d = RegValue;
          sq_d = SW'(SQUASH_CYCLES);
        end
        4'hE: begin
          le_d = 1'b1;
          lv_d = RegValue;
          sq_d = SW'(SQUASH_CYCLES);
          // A full stack still redirects; only the push is lost.
          if (cnt_q == CW'(STACK_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            stack_d[cnt_q[PW-1:0]] = InstrPC + 16'd1;
            cnt_d = cnt_q + 1'b1;
          end
        end
        4'hF: begin
          le_d = 1'b1;
          sq_d = SW'(SQUASH_CYCLES);
          if (cnt_q == '0) begin
            lv_d  = 16'h0000;
            err_d = 1'b1;
          end else begin
            lv_d  = stack_q[top_idx];
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      le_q  <= 1'b0;
      oe_q  <= 1'b0;
      lv_q  <= '0;
      off_q <= '0;
      sq_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      le_q    <= le_d;
      oe_q    <= oe_d;
      lv_q    <= lv_d;
      off_q   <= off_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign LoadEnable   = le_q;
  assign LoadValue    = lv_q;
  assign OffsetEnable = oe_q;
  assign Offset       = off_q;
  assign Squash       = (sq_q != '0);
  assign StackCount   = cnt_q;
  assign StackError   = err_q;

endmodule

// File: tb/tb_branch_control.sv
// Self-checking bench for branch_control: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_branch_control;

  localparam int D  = 8;
  localparam int SQ = 2;

  logic        Clock = 0;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr, InstrPC, RegValue;
  logic        FlagZ, FlagN, FlagC;
  logic        LoadEnable, OffsetEnable, Squash, StackError;
  logic [15:0] LoadValue;
  logic [8:0]  Offset;
  logic [$clog2(D):0] StackCount;

  branch_control #(.STACK_DEPTH(D), .SQUASH_CYCLES(SQ)) dut (
    .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .RegValue(RegValue),
    .FlagZ(FlagZ), .FlagN(FlagN), .FlagC(FlagC),
    .LoadEnable(LoadEnable), .LoadValue(LoadValue),
    .OffsetEnable(OffsetEnable), .Offset(Offset),
    .Squash(Squash), .StackCount(StackCount),
    .StackError(StackError)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_le, m_oe, m_err;
  logic [15:0] m_lv;
  logic [8:0]  m_off;
  int          m_sq;
  logic [15:0] m_stack [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(logic [2:0] c, logic z, logic n, logic cy);
    case (c)
      3'd0: return 1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return cy;
      3'd6: return !cy;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    bit acc, redirect;
    m_le = 0;
    m_oe = 0;
    if (Reset) begin
      m_lv = 0; m_off = 0; m_sq = 0; m_err = 0;
      m_stack.delete();
      return;
    end
    acc = InstrValid && (m_sq == 0);
    redirect = 0;
    if (acc) begin
      case (Instr[15:12])
        4'hC: if (cond_ok(Instr[11:9], FlagZ, FlagN, FlagC)) begin
          m_oe = 1; m_off = Instr[8:0]; redirect = 1;
        end
        4'hD: begin m_le = 1; m_lv = RegValue; redirect = 1; end
        4'hE: begin
          m_le = 1; m_lv = RegValue; redirect = 1;
          if (m_stack.size() < D) m_stack.push_back(InstrPC + 16'd1);
          else m_err = 1;
        end
        4'hF: begin
          m_le = 1; redirect = 1;
          if (m_stack.size() > 0) m_lv = m_stack.pop_back();
          else begin m_lv = 0; m_err = 1; end
        end
        default: ;
      endcase
    end
    if (redirect) m_sq = SQ;
    else if (m_sq > 0) m_sq--;
  endtask

  task automatic drive(logic v, logic [15:0] ins, logic [15:0] pc,
                       logic [15:0] rv, logic [2:0] f);
    InstrValid = v; Instr = ins; InstrPC = pc; RegValue = rv;
    {FlagZ, FlagN, FlagC} = f;
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(int n);
    drive(0, 16'h0, 16'h0, 16'h0, 3'b000);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all(string tag);
    chk({tag, ".le"},  LoadEnable, m_le);
    chk({tag, ".oe"},  OffsetEnable, m_oe);
    chk({tag, ".lv"},  LoadValue, m_lv);
    chk({tag, ".off"}, Offset, m_off);
    chk({tag, ".sq"},  Squash, m_sq != 0);
    chk({tag, ".cnt"}, StackCount, m_stack.size());
    chk({tag, ".err"}, StackError, m_err);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  flags;
    logic [15:0] pc;
    logic [15:0] rv;
    logic        le;
    logic        oe;
    logic [15:0] lv;
    logic [8:0]  off;
    logic        sq;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // {instr, flags ZNC, pc, rv, le, oe, lv, off, sq, cnt}
    tbl[0]  = '{16'hC1F0, 3'b000, 16'h0010, 16'h0, 0, 1, 16'h0, 9'h1F0, 1, 0};
    tbl[1]  = '{16'hC205, 3'b000, 16'h0011, 16'h0, 0, 0, 16'h0, 9'h000, 0, 0};
    tbl[2]  = '{16'hC205, 3'b100, 16'h0012, 16'h0, 0, 1, 16'h0, 9'h005, 1, 0};
    tbl[3]  = '{16'hC403, 3'b000, 16'h0013, 16'h0, 0, 1, 16'h0, 9'h003, 1, 0};
    tbl[4]  = '{16'hC611, 3'b010, 16'h0014, 16'h0, 0, 1, 16'h0, 9'h011, 1, 0};
    tbl[5]  = '{16'hC801, 3'b010, 16'h0015, 16'h0, 0, 0, 16'h0, 9'h000, 0, 0};
    tbl[6]  = '{16'hCA07, 3'b001, 16'h0016, 16'h0, 0, 1, 16'h0, 9'h007, 1, 0};
    tbl[7]  = '{16'hCC02, 3'b001, 16'h0017, 16'h0, 0, 0, 16'h0, 9'h000, 0, 0};
    tbl[8]  = '{16'hCEFF, 3'b111, 16'h0018, 16'h0, 0, 0, 16'h0, 9'h000, 0, 0};
    tbl[9]  = '{16'hD000, 3'b000, 16'h0019, 16'h1234, 1, 0, 16'h1234, 9'h0, 1, 0};
    tbl[10] = '{16'hE000, 3'b000, 16'h0100, 16'h0400, 1, 0, 16'h0400, 9'h0, 1, 1};
    tbl[11] = '{16'hF000, 3'b000, 16'h0200, 16'h0777, 1, 0, 16'h0101, 9'h0, 1, 0};
    tbl[12] = '{16'h1234, 3'b111, 16'h0300, 16'h0555, 0, 0, 16'h0, 9'h0, 0, 0};

    // reset and idle
    Reset = 1;
    idle(3);
    check_all("reset");
    Reset = 0;
    idle(1);
    check_all("idle");

    // vector table
    foreach (tbl[i]) begin
      drive(1, tbl[i].instr, tbl[i].pc, tbl[i].rv, tbl[i].flags);
      tick();
      chk($sformatf("tbl%0d.le", i), LoadEnable, tbl[i].le);
      chk($sformatf("tbl%0d.oe", i), OffsetEnable, tbl[i].oe);
      chk($sformatf("tbl%0d.sq", i), Squash, tbl[i].sq);
      chk($sformatf("tbl%0d.cnt", i), StackCount, tbl[i].cnt);
      if (tbl[i].le) chk($sformatf("tbl%0d.lv", i), LoadValue, tbl[i].lv);
      if (tbl[i].oe) chk($sformatf("tbl%0d.off", i), Offset, tbl[i].off);
      idle(3);
    end

    // instruction presented during squash is ignored
    drive(1, 16'hC1F0, 16'h0040, 16'h0, 3'b000);
    tick();
    chk("sq.n1.oe", OffsetEnable, 1);
    chk("sq.n1.sq", Squash, 1);
    drive(1, 16'hD000, 16'h0041, 16'hBEEF, 3'b000);
    tick();
    chk("sq.n2.le", LoadEnable, 0);
    chk("sq.n2.oe", OffsetEnable, 0);
    chk("sq.n2.sq", Squash, 1);
    idle(1);
    chk("sq.n3.sq", Squash, 0);
    chk("sq.n3.le", LoadEnable, 0);
    check_all("sq.end");

    // stack overflow then underflow
    Reset = 1; idle(1); Reset = 0;
    for (int i = 0; i <= D; i++) begin
      drive(1, 16'hE000, 16'(16 * i), 16'(16'h2000 + i), 3'b000);
      tick();
      chk($sformatf("call%0d.le", i), LoadEnable, 1);
      chk($sformatf("call%0d.lv", i), LoadValue, 16'h2000 + i);
      idle(2);
    end
    chk("ovf.cnt", StackCount, D);
    chk("ovf.err", StackError, 1);
    for (int i = D - 1; i >= 0; i--) begin
      drive(1, 16'hF000, 16'h0, 16'h0, 3'b000);
      tick();
      chk($sformatf("ret%0d.lv", i), LoadValue, 16 * i + 1);
      idle(2);
    end
    chk("pop.cnt", StackCount, 0);
    Reset = 1; idle(1); Reset = 0;
    chk("rst.err", StackError, 0);
    drive(1, 16'hF000, 16'h0, 16'hAAAA, 3'b000);
    tick();
    chk("unf.le", LoadEnable, 1);
    chk("unf.lv", LoadValue, 0);
    chk("unf.err", StackError, 1);
    chk("unf.cnt", StackCount, 0);
    idle(2);

    // reset in the middle of a squash after CALL
    Reset = 1; idle(1); Reset = 0;
    drive(1, 16'hE000, 16'h0100, 16'h0400, 3'b000);
    tick();
    chk("rc.le", LoadEnable, 1);
    chk("rc.sq", Squash, 1);
    Reset = 1;
    idle(1);
    chk("rc.sq0", Squash, 0);
    chk("rc.cnt0", StackCount, 0);
    chk("rc.le0", LoadEnable, 0);
    chk("rc.oe0", OffsetEnable, 0);
    Reset = 0;
    idle(1);
    check_all("rc.after");

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  op;
      logic [15:0] w;
      int          sel;
      sel = $urandom_range(0, 5);
      op  = (sel < 4) ? 4'(4'hC + sel) : 4'($urandom_range(0, 15));
      w   = {op, 12'($urandom)};
      drive(($urandom_range(0, 3) != 0), w, 16'($urandom),
            16'($urandom), 3'($urandom));
      if ($urandom_range(0, 99) == 0) Reset = 1;
      tick();
      Reset = 0;
      check_all($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
